// File: rtl/ss_chan_pkg.sv
// ss_pkg: shared state encoding, descriptor word indices and beat width for the channel engine.
package ss_pkg;
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_REQ   = 4'd2,
        S_BURST = 4'd3,
        S_DRAIN = 4'd4,
        S_DONE  = 4'd5
    } state_e;
    localparam int SS_IDX_SRC = 2;
    localparam int SS_IDX_LEN = 3;
    localparam int SS_BEAT_W  = 64;
endpackage

// File: rtl/ss_chan_fifo.sv
// ss_fifo: show-ahead synchronous FIFO with flush and a free-entry count.
module ss_fifo #(
    parameter int W  = 64,
    parameter int AW = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  free_o
);
    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
    logic [W-1:0]  mem_q [1 << AW];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          wr, rd;
    assign wr      = push_i & ~full_o;
    assign rd      = pop_i & ~empty_o;
    assign full_o  = cnt_q == DEPTH;
    assign empty_o = cnt_q == '0;
    assign free_o  = DEPTH - cnt_q;
    assign dout_o  = mem_q[rp_q];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(wr);
            rp_q  <= rp_q + AW'(rd);
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wp_q] <= din_i;
    end
endmodule

// File: rtl/ss_chan.sv
// ss_chan: descriptor-driven Wishbone burst reader feeding a 64-bit stream.
// Define SS_CHAN_ERR_ABORT_EN to make wbm_err_i abort the transfer instead of retrying.
module ss_chan
    import ss_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int BURST   = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 ss_we,
    input  logic [1:0]           ss_adr,
    input  logic [31:0]          ss_dat,
    input  logic [23:0]          ss_dc,
    input  logic                 ss_done,
    input  logic                 m_enable,
    input  logic                 m_reset,
    output logic                 c_done,
    output logic [15:0]          ocnt,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cab_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_adr_o,
    input  logic [31:0]          wbm_dat_i,
    input  logic [31:0]          wbm_dat64_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    output logic [SS_BEAT_W-1:0] src_dat_o,
    output logic                 src_valid_o,
    input  logic                 src_ready_i,
    output logic                 ch_err
);
    localparam logic [15:0] BL = 16'(BURST);
    state_e           state_q, state_d;
    logic [28:0]      cur_q, cur_d;
    logic [15:0]      rem_q, rem_d, blen_q, blen_d, ocnt_q, ocnt_d, need;
    logic             cyc_q, cyc_d, err_q, err_d;
    logic [FIFO_AW:0] free;
    logic             empty, full, good, bad, pop, last, unused_ok;
    assign pop  = src_valid_o & src_ready_i;
    assign need = rem_q < BL ? rem_q : BL;
    assign last = blen_q == 16'd1 || rem_q == 16'd1;
    // err counts as a retry unless the abort build is selected
    assign good = state_q == S_BURST && wbm_ack_i && !wbm_rty_i && !wbm_err_i;
`ifdef SS_CHAN_ERR_ABORT_EN
    assign bad = state_q == S_BURST && wbm_err_i;
`else
    assign bad = 1'b0;
`endif
    assign unused_ok   = ^{ss_dc, ss_dat[2:0], full};
    assign c_done      = state_q == S_DONE;
    assign ocnt        = ocnt_q;
    assign ch_err      = err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_cab_o   = cyc_q;
    assign wbm_we_o    = 1'b0;
    assign wbm_sel_o   = {4{cyc_q}};
    assign wbm_adr_o   = {cur_q, 3'b000};
    assign src_valid_o = ~empty;
    ss_fifo #(.W(SS_BEAT_W), .AW(FIFO_AW)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (good),
        .pop_i   (pop),
        .flush_i (m_reset),
        .din_i   ({wbm_dat64_i, wbm_dat_i}),
        .dout_o  (src_dat_o),
        .full_o  (full),
        .empty_o (empty),
        .free_o  (free)
    );
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            blen_q  <= '0;
            ocnt_q  <= '0;
            cyc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            blen_q  <= blen_d;
            ocnt_q  <= ocnt_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (m_reset) state_d = S_IDLE;
        else case (state_q)
            S_IDLE:  state_d = ss_we ? S_LOAD : S_IDLE;
            S_LOAD:  if (m_enable) state_d = rem_q == '0 ? S_DONE : S_REQ;
            S_REQ:   if (m_enable && 16'(free) >= need) state_d = S_BURST;
            S_BURST: if (bad) state_d = S_DRAIN;
                     else if (good && last) state_d = rem_q == 16'd1 ? S_DRAIN : S_REQ;
            S_DRAIN: state_d = empty ? S_DONE : S_DRAIN;
            S_DONE:  state_d = ss_done ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end
    always_comb begin
        cur_d  = cur_q;
        rem_d  = rem_q;
        blen_d = blen_q;
        cyc_d  = cyc_q;
        err_d  = err_q;
        ocnt_d = pop ? ocnt_q + 16'd1 : ocnt_q;
        if (ss_we && (state_q == S_IDLE || state_q == S_LOAD)) begin
            cur_d = ss_adr == 2'(SS_IDX_SRC) ? ss_dat[31:3] : cur_q;
            rem_d = ss_adr == 2'(SS_IDX_LEN) ? ss_dat[18:3] : rem_q;
        end
        if (state_q == S_IDLE && ss_we) ocnt_d = '0;
        if (state_q == S_REQ && state_d == S_BURST) begin
            cyc_d  = 1'b1;
            blen_d = need;
        end
        if (good) begin
            cur_d  = cur_q + 29'd1;
            rem_d  = rem_q - 16'd1;
            blen_d = blen_q - 16'd1;
            cyc_d  = last ? 1'b0 : cyc_q;
        end
        if (bad) begin
            cyc_d = 1'b0;
            err_d = 1'b1;
            rem_d = '0;
        end
        if (m_reset) begin
            cyc_d  = 1'b0;
            err_d  = 1'b0;
            ocnt_d = '0;
        end
    end
endmodule

// File: tb/tb_ss_chan.sv
// tb_ss_chan: scoreboard bench for ss_chan with a zero-wait Wishbone memory model.
module tb_ss_chan;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ss_we = 1'b0, ss_done = 1'b0, m_enable = 1'b0, m_reset = 1'b0;
    logic [1:0]  ss_adr = 2'd0;
    logic [31:0] ss_dat = '0;
    logic [23:0] ss_dc = 24'h008000;
    logic        c_done, cyc, stb, we, cab, src_valid, ch_err;
    logic [15:0] ocnt;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat = '0, dat64 = '0;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0, src_ready = 1'b1;
    logic [63:0] src_dat, mon_exp;
    int          tests = 0, fails = 0;
    logic [63:0] sb[$];
    logic [31:0] bst[$];
    int          n_acc = 0, rty_at = -1, err_at = -1;
    bit          prev_cyc = 0, rty_pend = 0, rty_done = 0, err_done = 0;
    logic [31:0] rty_adr = '0, rty_re = '0;
`ifdef SS_CHAN_ERR_ABORT_EN
    localparam int ERR_OCNT = 4;
    localparam logic ERR_FLAG = 1'b1;
`else
    localparam int ERR_OCNT = 10;
    localparam logic ERR_FLAG = 1'b0;
`endif

    ss_chan #(.FIFO_AW(3), .BURST(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .ss_we(ss_we), .ss_adr(ss_adr), .ss_dat(ss_dat),
        .ss_dc(ss_dc), .ss_done(ss_done), .m_enable(m_enable), .m_reset(m_reset),
        .c_done(c_done), .ocnt(ocnt), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
        .wbm_cab_o(cab), .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_i(dat),
        .wbm_dat64_i(dat64), .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty),
        .src_dat_o(src_dat), .src_valid_o(src_valid), .src_ready_i(src_ready), .ch_err(ch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mdat(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    // Memory slave: responses set on the falling edge, sampled by the DUT on the next rising edge.
    always @(negedge clk) begin
        ack = 1'b0;
        rty = 1'b0;
        err = 1'b0;
        if (cyc && stb) begin
            if (!prev_cyc) bst.push_back(adr);
            if (rty_pend) begin rty_re = adr; rty_pend = 0; end
            {dat64, dat} = mdat(adr);
            if (n_acc == rty_at && !rty_done) begin
                ack = 1'b1; rty = 1'b1; rty_done = 1; rty_adr = adr; rty_pend = 1;
            end else if (n_acc == err_at && !err_done) begin
                err = 1'b1; err_done = 1;
            end else begin
                ack = 1'b1; n_acc++;
            end
        end
        prev_cyc = cyc;
    end

    // Stream monitor: checks each beat that will be consumed at the next rising edge.
    always begin
        @(negedge clk);
        #2;
        if (src_valid && src_ready && !rst) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL stream_extra got %h want no beat", src_dat);
            end else begin
                mon_exp = sb.pop_front();
                if (src_dat !== mon_exp) begin
                    fails++;
                    $display("FAIL stream_data got %h want %h", src_dat, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        n_acc = 0; rty_at = -1; err_at = -1; rty_done = 0; err_done = 0;
        rty_adr = '0; rty_re = '0;
        bst.delete();
    endtask

    task automatic load(input logic [31:0] src, input logic [15:0] len, input int n);
        for (int i = 0; i < n; i++) sb.push_back(mdat(src + 32'(i) * 32'd8));
        tick(); ss_we = 1'b1; ss_adr = 2'd2; ss_dat = src;
        tick(); ss_adr = 2'd3; ss_dat = {13'd0, len, 3'd0};
        tick(); ss_we = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 600 && c_done !== 1'b1; i++) tick();
        tests++;
        if (c_done !== 1'b1) begin fails++; $display("FAIL %s_done_timeout got %b want 1", nm, c_done); end
    endtask

    task automatic finish_xfer(input string nm);
        m_enable = 1'b0; ss_done = 1'b1; tick(); ss_done = 1'b0;
        tests++;
        if (c_done !== 1'b0) begin fails++; $display("FAIL %s_done_clear got %b want 0", nm, c_done); end
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL %s_missing_beats got %0d left want 0", nm, sb.size()); end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        tests++;
        if ({cyc, stb, we, cab, sel} !== 8'h00) begin fails++; $display("FAIL reset_wb got %b want 0", {cyc, stb, we, cab, sel}); end
        tests++;
        if (adr !== 32'h0) begin fails++; $display("FAIL reset_adr got %h want 0", adr); end
        tests++;
        if ({c_done, ch_err, src_valid} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {c_done, ch_err, src_valid}); end
        tests++;
        if (ocnt !== 16'd0) begin fails++; $display("FAIL reset_ocnt got %0d want 0", ocnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        clr(); load(32'h1000, 16'd6, 6); m_enable = 1'b1;
        wait_done("basic");
        tests++;
        if (ocnt !== 16'd6) begin fails++; $display("FAIL basic_ocnt got %0d want 6", ocnt); end
        tests++;
        if (bst.size() != 2 || bst[0] !== 32'h1000 || bst[1] !== 32'h1020) begin
            fails++; $display("FAIL basic_bursts got %0d bursts want 2 at 1000/1020", bst.size());
        end
        finish_xfer("basic");
    endtask

    task automatic test_backpressure();
        clr(); src_ready = 1'b0; load(32'h2000, 16'd20, 20); m_enable = 1'b1;
        repeat (40) tick();
        tests++;
        if (n_acc != 8 || bst.size() != 2) begin fails++; $display("FAIL bp_fill got %0d beats/%0d bursts want 8/2", n_acc, bst.size()); end
        tests++;
        if (cyc !== 1'b0 || src_valid !== 1'b1) begin fails++; $display("FAIL bp_stall got cyc=%b valid=%b want 0/1", cyc, src_valid); end
        src_ready = 1'b1;
        wait_done("bp");
        tests++;
        if (ocnt !== 16'd20 || n_acc != 20) begin fails++; $display("FAIL bp_count got ocnt=%0d acks=%0d want 20", ocnt, n_acc); end
        finish_xfer("bp");
    endtask

    task automatic test_zero_length();
        clr(); load(32'h3000, 16'd0, 0); m_enable = 1'b1;
        tick();
        tests++;
        if (c_done !== 1'b1) begin fails++; $display("FAIL zero_done got %b want 1", c_done); end
        tests++;
        if (bst.size() != 0 || cyc !== 1'b0 || ocnt !== 16'd0) begin
            fails++; $display("FAIL zero_idle got bursts=%0d cyc=%b ocnt=%0d want 0", bst.size(), cyc, ocnt);
        end
        finish_xfer("zero");
    endtask

    task automatic test_retry();
        clr(); rty_at = 1; load(32'h1000, 16'd4, 4); m_enable = 1'b1;
        wait_done("retry");
        tests++;
        if (rty_adr !== 32'h1008 || rty_re !== 32'h1008) begin
            fails++; $display("FAIL retry_adr got %h then %h want 1008", rty_adr, rty_re);
        end
        tests++;
        if (ocnt !== 16'd4 || n_acc != 4) begin fails++; $display("FAIL retry_count got ocnt=%0d acks=%0d want 4", ocnt, n_acc); end
        finish_xfer("retry");
    endtask

    task automatic test_wrap();
        clr(); load(32'hFFFF_FFF0, 16'd3, 3); m_enable = 1'b1;
        wait_done("wrap");
        tests++;
        if (bst.size() != 1 || bst[0] !== 32'hFFFF_FFF0 || ocnt !== 16'd3) begin
            fails++; $display("FAIL wrap_burst got %0d bursts ocnt=%0d want 1 burst ocnt=3", bst.size(), ocnt);
        end
        finish_xfer("wrap");
    endtask

    task automatic test_mid_reset();
        clr(); src_ready = 1'b0; load(32'h4000, 16'd8, 0); m_enable = 1'b1;
        for (int i = 0; i < 100 && n_acc < 3; i++) tick();
        tests++;
        if (n_acc != 3) begin fails++; $display("FAIL mrst_reach got %0d beats want 3", n_acc); end
        m_reset = 1'b1; m_enable = 1'b0;
        tick();
        m_reset = 1'b0;
        tests++;
        if (cyc !== 1'b0) begin fails++; $display("FAIL mrst_cyc got %b want 0", cyc); end
        tests++;
        if ({src_valid, c_done} !== 2'b00 || ocnt !== 16'd0) begin
            fails++; $display("FAIL mrst_flush got valid=%b done=%b ocnt=%0d want 0", src_valid, c_done, ocnt);
        end
        tests++;
        if (dut.state_q !== 4'd0) begin fails++; $display("FAIL mrst_state got %0d want 0", dut.state_q); end
        src_ready = 1'b1;
        repeat (3) tick();
        tests++;
        if (n_acc != 3 || src_valid !== 1'b0) begin fails++; $display("FAIL mrst_quiet got acks=%0d valid=%b want 3/0", n_acc, src_valid); end
    endtask

    task automatic test_error();
        clr(); err_at = 4; load(32'h5000, 16'd10, ERR_OCNT); m_enable = 1'b1;
        wait_done("err");
        tests++;
        if (ch_err !== ERR_FLAG) begin fails++; $display("FAIL err_flag got %b want %b", ch_err, ERR_FLAG); end
        tests++;
        if (ocnt !== 16'(ERR_OCNT)) begin fails++; $display("FAIL err_ocnt got %0d want %0d", ocnt, ERR_OCNT); end
        finish_xfer("err");
        m_reset = 1'b1; tick(); m_reset = 1'b0;
        tests++;
        if (ch_err !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", ch_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_length();
        test_retry();
        test_wrap();
        test_mid_reset();
        test_error();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired after %0d checks", tests);
        $fatal(1, "watchdog");
    end
endmodule
